// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_pkg
// Brief    : Shared scope constants and capture state encoding for the
//            capture, waveform and grid blocks.
// Revision : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int C_DEPTH    = 600;
    localparam int C_SAMPLE_W = 12;
    localparam int C_ADDR_W   = 10;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_ram.sv
`default_nettype none
// ============================================================================
// Module   : sample_ram
// Brief    : DEPTH x SAMPLE_W buffer, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module sample_ram
    import scope_pkg::*;
#(
    parameter int DEPTH    = C_DEPTH,
    parameter int SAMPLE_W = C_SAMPLE_W,
    parameter int ADDR_W   = C_ADDR_W
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [SAMPLE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [SAMPLE_W-1:0] o_rdata
);

    localparam logic [ADDR_W:0] C_DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];

    // Out-of-range addresses neither write nor read; the caller masks the data.
    always_ff @(posedge clk) begin
        if (i_we && ({1'b0, i_waddr} < C_DEPTH_X)) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if ({1'b0, i_raddr} < C_DEPTH_X) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Brief    : Rising-edge / auto triggered sample capture into a ping-pong
//            buffer, swapped to the display side only at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_capture
    import scope_pkg::*;
#(
    parameter int DEPTH        = C_DEPTH,
    parameter int SAMPLE_W     = C_SAMPLE_W,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                frame_start,
    input  logic [C_ADDR_W-1:0] rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                triggered,
    output logic [15:0]         capture_count
);

    localparam int                 C_CNT_W   = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(AUTO_TIMEOUT);
    localparam logic [C_ADDR_W-1:0] C_LAST   = C_ADDR_W'(DEPTH - 1);
    localparam logic [C_ADDR_W:0]  C_DEPTH_X = (C_ADDR_W + 1)'(DEPTH);

    cap_state_t            r_state;
    logic                  r_display_sel;
    logic [C_ADDR_W-1:0]   r_wr_ptr;
    logic [C_CNT_W-1:0]    r_to_cnt;
    logic [SAMPLE_W-1:0]   r_prev;
    logic                  r_prev_vld;
    logic                  r_trig_flag;
    logic                  r_rd_sel;
    logic                  r_rd_zero;

    logic                  w_edge;
    logic [C_CNT_W-1:0]    w_to_next;
    logic                  w_timeout;
    logic                  w_start;
    logic                  w_cap_wr;
    logic                  w_we;
    logic [C_ADDR_W-1:0]   w_waddr;
    logic [SAMPLE_W-1:0]   w_q0;
    logic [SAMPLE_W-1:0]   w_q1;

    // r_prev_vld keeps the very first strobe after reset from ever triggering.
    assign w_edge    = r_prev_vld && (r_prev < trig_level) && (sample >= trig_level);
    assign w_to_next = (r_to_cnt == C_TIMEOUT) ? r_to_cnt : r_to_cnt + 1'b1;
    assign w_timeout = (w_to_next == C_TIMEOUT);
    assign w_start   = !reset && sample_valid && (r_state == ST_ARM) && (w_edge || w_timeout);
    assign w_cap_wr  = !reset && sample_valid && (r_state == ST_CAPTURE);
    assign w_we      = w_start || w_cap_wr;
    assign w_waddr   = w_start ? '0 : r_wr_ptr;

    sample_ram #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (C_ADDR_W)
    ) u_buf0 (
        .clk     (clk),
        .i_we    (w_we && r_display_sel),
        .i_waddr (w_waddr),
        .i_wdata (sample),
        .i_raddr (rd_addr),
        .o_rdata (w_q0)
    );

    sample_ram #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (C_ADDR_W)
    ) u_buf1 (
        .clk     (clk),
        .i_we    (w_we && !r_display_sel),
        .i_waddr (w_waddr),
        .i_wdata (sample),
        .i_raddr (rd_addr),
        .o_rdata (w_q1)
    );

    // Select and range mask are captured alongside the RAM read address.
    assign rd_data = r_rd_zero ? '0 : (r_rd_sel ? w_q1 : w_q0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ARM;
            r_display_sel <= 1'b0;
            r_wr_ptr      <= '0;
            r_to_cnt      <= '0;
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_trig_flag   <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_rd_zero     <= 1'b1;
            triggered     <= 1'b0;
            capture_count <= '0;
        end else begin
            r_rd_sel  <= r_display_sel;
            r_rd_zero <= ({1'b0, rd_addr} >= C_DEPTH_X);
            if (sample_valid) begin
                r_prev     <= sample;
                r_prev_vld <= 1'b1;
            end
            case (r_state)
                ST_ARM: begin
                    if (sample_valid) begin
                        r_to_cnt <= w_to_next;
                        if (w_edge || w_timeout) begin
                            r_wr_ptr    <= C_ADDR_W'(1);
                            r_trig_flag <= w_edge;
                            r_state     <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_start) begin
                        r_display_sel <= ~r_display_sel;
                        triggered     <= r_trig_flag;
                        capture_count <= capture_count + 16'd1;
                        r_to_cnt      <= '0;
                        r_state       <= ST_ARM;
                    end
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Brief    : Randomized scoreboard bench for trigger_capture against a
//            buffer-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int DEPTH = 600;
    localparam int SW    = 12;
    localparam int AUTO  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic [SW-1:0] trig_level;
    logic          frame_start;
    logic [9:0]    rd_addr;
    logic [SW-1:0] rd_data;
    logic          triggered;
    logic [15:0]   capture_count;

    always #5 clk = ~clk;

    trigger_capture #(
        .DEPTH        (DEPTH),
        .SAMPLE_W     (SW),
        .AUTO_TIMEOUT (AUTO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .trig_level    (trig_level),
        .frame_start   (frame_start),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .triggered     (triggered),
        .capture_count (capture_count)
    );

    typedef struct {
        int rd;
        bit rd_known;
        bit trig;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: two sample buffers (-1 = never written), which one is shown,
    // and how far the back-buffer fill has progressed (-1 = waiting to arm).
    int mem [2][DEPTH];
    int m_disp, m_phase, m_flag, m_trig, m_count;
    int m_prev, m_prev_ok, m_armed;

    function automatic int rnd_addr();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(DEPTH, 1023));
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic cycle(input bit rst, input bit sv, input int smp, input bit fs, input int addr);
        exp_t e;
        int   lvl;
        @(negedge clk);
        reset        = rst;
        sample_valid = sv;
        sample       = smp[SW-1:0];
        frame_start  = fs;
        rd_addr      = addr[9:0];
        lvl          = int'(trig_level);

        if (rst || addr >= DEPTH) begin
            e.rd       = 0;
            e.rd_known = 1'b1;
        end else begin
            e.rd       = mem[m_disp][addr];
            e.rd_known = (e.rd >= 0);
        end

        if (rst) begin
            m_phase = -1; m_disp = 0; m_trig = 0; m_count = 0;
            m_prev = 0; m_prev_ok = 0; m_armed = 0;
        end else begin
            if (fs && m_phase == DEPTH) begin
                m_disp  = 1 - m_disp;
                m_trig  = m_flag;
                m_count = (m_count + 1) % 65536;
                m_armed = 0;
                m_phase = -1;
            end else if (sv) begin
                if (m_phase == -1) begin
                    m_armed++;
                    if (m_prev_ok != 0 && m_prev < lvl && smp >= lvl) begin
                        m_flag = 1;
                        mem[1 - m_disp][0] = smp;
                        m_phase = 1;
                    end else if (m_armed >= AUTO) begin
                        m_flag = 0;
                        mem[1 - m_disp][0] = smp;
                        m_phase = 1;
                    end
                end else if (m_phase < DEPTH) begin
                    mem[1 - m_disp][m_phase] = smp;
                    m_phase++;
                end
            end
            if (sv) begin
                m_prev    = smp;
                m_prev_ok = 1;
            end
        end
        e.trig = m_trig[0];
        e.cnt  = m_count;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a read result and status.
    always @(posedge clk) begin
        exp_t       e;
        logic [SW-1:0] w_exp_rd;
        logic [15:0]   w_exp_cnt;
        #1;
        if (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            w_exp_rd  = e.rd[SW-1:0];
            w_exp_cnt = e.cnt[15:0];
            if (e.rd_known) begin
                total++;
                if (rd_data !== w_exp_rd) begin
                    bad++;
                    $display("FAIL rd_data t=%0t got=%0d expected=%0d", $time, rd_data, w_exp_rd);
                end
            end
            total++;
            if (triggered !== e.trig) begin
                bad++;
                $display("FAIL triggered t=%0t got=%0b expected=%0b", $time, triggered, e.trig);
            end
            total++;
            if (capture_count !== w_exp_cnt) begin
                bad++;
                $display("FAIL capture_count t=%0t got=%0d expected=%0d", $time, capture_count, w_exp_cnt);
            end
        end
    end

    task automatic strobe(input int smp);
        cycle(1'b0, 1'b1, smp, 1'b0, rnd_addr());
    endtask

    task automatic frame();
        cycle(1'b0, 1'b0, 0, 1'b1, rnd_addr());
    endtask

    task automatic read_at(input int addr);
        cycle(1'b0, 1'b0, 0, 1'b0, addr);
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) read_at(a);
        read_at(DEPTH);
        read_at(1023);
    endtask

    // Drive the design back to an armed state right after a swap.
    task automatic settle();
        for (int i = 0; i < 4000 && m_phase != -1; i++) begin
            if (m_phase == DEPTH) frame();
            else strobe(int'($urandom_range(0, 4095)));
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) mem[b][a] = -1;
        m_disp = 0; m_phase = -1; m_flag = 0; m_trig = 0; m_count = 0;
        m_prev = 0; m_prev_ok = 0; m_armed = 0;
        reset = 1'b1; sample_valid = 1'b0; sample = '0; frame_start = 1'b0;
        rd_addr = '0; trig_level = 12'd2048;

        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0, 0);

        // Ramp trigger: capture starts at 2050
        for (int v = 2000; v <= 2100; v += 10) strobe(v);
        for (int i = 0; i < DEPTH - 6; i++) begin
            if ($urandom_range(0, 3) == 0) read_at(rnd_addr());
            strobe(int'($urandom_range(0, 4095)));
        end
        read_at(0);
        frame();
        read_at(0);
        read_at(599);
        read_at(600);
        read_at(1023);
        read_at(5);

        // Captures completing between frame starts
        for (int i = 0; i < 2500; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                  (i % 400) == 399, rnd_addr());
        end

        // Auto capture on constant input
        settle();
        for (int i = 0; i < DEPTH + AUTO - 1; i++) strobe(100);
        read_at(3);
        frame();
        sweep();

        // Last write coincides with frame_start
        settle();
        strobe(0);
        strobe(3000);
        for (int i = 0; i < DEPTH - 2; i++) strobe(int'($urandom_range(0, 4095)));
        cycle(1'b0, 1'b1, 1234, 1'b1, 0);
        for (int i = 0; i < 5; i++) read_at(DEPTH - 1 - i);
        frame();
        read_at(DEPTH - 1);
        read_at(0);

        // Reset in the middle of a capture
        settle();
        strobe(0);
        strobe(3000);
        for (int i = 0; i < 299; i++) strobe(int'($urandom_range(0, 4095)));
        repeat (2) cycle(1'b1, 1'b1, 4000, 1'b1, 0);
        strobe(4000);
        strobe(0);
        strobe(2500);
        for (int i = 0; i < DEPTH - 1; i++) strobe(int'($urandom_range(0, 4095)));
        frame();
        sweep();

        // Random mix with occasional level changes and resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) trig_level = SW'($urandom_range(0, 4095));
            cycle($urandom_range(0, 2499) == 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4095)), $urandom_range(0, 249) == 0, rnd_addr());
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter DEPTH, default 600: samples per capture, equal to the waveform plot width in pixels.
REQ-002 Parameter SAMPLE_W, default 12: ADC sample width.
REQ-003 Parameter AUTO_TIMEOUT, default 4096: samples waited for a trigger before a forced (auto) capture.
REQ-004 Port clk, input, 1: single clock (VGA pixel clock, 25.2 MHz); the block uses one clock; reset is synchronous and active-high.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port sample_valid, input, 1: one-cycle strobe from the ADC when sample holds a new conversion.
REQ-007 Port sample, input, SAMPLE_W: ADC conversion result, valid when sample_valid is 1.
REQ-008 Port trig_level, input, SAMPLE_W: rising-edge trigger threshold.
REQ-009 Port frame_start, input, 1: one-cycle pulse at pixel (0,0) of each video frame.
REQ-010 Port rd_addr, input, 10: column index requested by the waveform renderer.
REQ-011 Port rd_data, output, SAMPLE_W: sample stored at rd_addr in the display buffer.
REQ-012 Port triggered, output, 1: level; 1 while the display buffer holds an edge-triggered capture, 0 for an auto capture.
REQ-013 Port capture_count, output, 16: number of buffer swaps since reset; wraps modulo 2^16.

Function
REQ-014 Storage shall be two DEPTH x SAMPLE_W buffers (ping-pong), with display_sel selecting the display buffer; capture always writes the other buffer.
REQ-015 States shall be ARM, CAPTURE and DONE.
REQ-016 ARM: on each sample_valid, when prev < trig_level and sample >= trig_level, the block shall write sample to address 0, set wr_ptr=1 and enter CAPTURE with trig_flag=1.
REQ-017 ARM: the block shall count sample_valid strobes; when the count reaches AUTO_TIMEOUT with no trigger, the current sample shall be written to address 0 and the block shall enter CAPTURE with trig_flag=0.
REQ-018 prev shall update on every sample_valid in every state; after reset, the first strobe shall never trigger.
REQ-019 CAPTURE: each sample_valid shall write the sample at wr_ptr and increment wr_ptr; after the write at DEPTH-1 the block shall enter DONE.
REQ-020 DONE: on frame_start the block shall toggle display_sel, latch triggered<=trig_flag, increment capture_count, clear the timeout counter and enter ARM, all in the same cycle.
REQ-021 frame_start in ARM or CAPTURE shall have no effect; the display buffer stays unchanged for the whole frame.
REQ-022 If the last CAPTURE write and frame_start coincide, the block shall enter DONE; the swap shall occur at the next frame_start, never mid-frame.
REQ-023 sample_valid in DONE shall be ignored, except for the prev update.
REQ-024 rd_data shall be registered with 1-cycle latency: rd_data(t+1) = display_buffer[rd_addr(t)].
REQ-025 When rd_addr >= DEPTH, rd_data shall be 0 on the next cycle.
REQ-026 Sample comparisons shall be unsigned at SAMPLE_W bits; the timeout counter shall saturate and never wrap.

Reset
REQ-027 Reset shall set: state=ARM, display_sel=0, wr_ptr=0, timeout count=0, prev=0, triggered=0, capture_count=0, rd_data=0.
REQ-028 Buffer contents shall not be cleared by reset.
REQ-029 Reset asserted mid-CAPTURE shall abandon the partial capture; the next capture shall restart at address 0.
REQ-030 While reset is high, sample_valid and frame_start shall be ignored.

Structure
REQ-031 DEPTH, SAMPLE_W, the state encodings and the address width (10) shall be defined in a shared scope_pkg, also used by the waveform and grid blocks.
REQ-032 One sub-module, sample_ram (single write port, registered read port, DEPTH x SAMPLE_W), shall be instantiated twice.

Verification
REQ-033 Trigger: trig_level=2048, ramp 2000,2010,...,2100 on strobes -> capture starts at 2050; after 600 strobes and one frame_start, rd_addr=0 gives 2050, triggered=1, capture_count=1.
REQ-034 Auto: constant sample 100, AUTO_TIMEOUT=16 -> capture begins on the 16th strobe; after swap, rd_data=100 at all addresses and triggered=0.
REQ-035 Mid-frame completion: capture finishes between frame_starts -> rd_data stays at old values until the next frame_start, then switches.
REQ-036 Coincidence: last write and frame_start in the same cycle -> no swap that cycle; swap occurs at the following frame_start.
REQ-037 Reset mid-capture at wr_ptr=300 -> after reset, state=ARM, capture_count=0, and the next capture writes address 0 first.
REQ-038 Read edge: rd_addr=599 returns stored data, rd_addr=600 and 1023 return 0, each one cycle later.
